// File: rtl/stream_out_vector_ping_pong_if.sv
// Element stream produced by the vector ping-pong buffer: valid/ready handshake plus
// element data, its index within the vector and an end-of-vector marker.
interface stream_out_vector_ping_pong_if #(
    parameter int unsigned BITS = 8,
    parameter int unsigned N    = 3
);
    localparam int unsigned IDX_BITS = $clog2(N);

    logic                out_valid;
    logic                out_ready;
    logic [BITS-1:0]     out_data;
    logic [IDX_BITS-1:0] out_index;
    logic                out_last;

    modport master (
        output out_valid,
        output out_data,
        output out_index,
        output out_last,
        input  out_ready
    );

    modport slave (
        input  out_valid,
        input  out_data,
        input  out_index,
        input  out_last,
        output out_ready
    );
endinterface

// File: rtl/stream_out_vector_ping_pong.sv
// Accepts whole N-element vectors on a one-cycle pulse and streams them out element by element,
// double-buffered (active + pending bank) because the upstream cannot be stalled.
module stream_out_vector_ping_pong #(
    parameter int unsigned BITS     = 8,
    parameter int unsigned N        = 3,
    parameter int unsigned CNT_BITS = 8
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         in_valid,
    input  logic [BITS-1:0]              in_vec [N],
    input  logic                         clear_overflow,
    output logic                         busy,
    output logic                         overflow,
    output logic [CNT_BITS-1:0]          drop_count,
    stream_out_vector_ping_pong_if.master out
);
    localparam int unsigned IDX_BITS = $clog2(N);
    localparam logic [IDX_BITS-1:0] LAST_IDX = IDX_BITS'(N - 1);
    localparam logic [CNT_BITS-1:0] CNT_MAX  = {CNT_BITS{1'b1}};

    typedef enum logic [0:0] {StIdle, StStream} state_e;

    state_e              state_q, state_d;
    logic [IDX_BITS-1:0] idx_q, idx_d;
    logic [BITS-1:0]     act_q [N];
    logic [BITS-1:0]     act_d [N];
    logic [BITS-1:0]     pend_q [N];
    logic [BITS-1:0]     pend_d [N];
    logic                pend_v_q, pend_v_d;
    logic                overflow_q, overflow_d;
    logic [CNT_BITS-1:0] drop_count_q, drop_count_d;

    logic act_v;
    logic fire;
    logic act_free;
    logic drop;

    assign act_v = (state_q == StStream);
    assign fire  = act_v & out.out_ready;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= StIdle;
            idx_q        <= '0;
            pend_v_q     <= 1'b0;
            overflow_q   <= 1'b0;
            drop_count_q <= '0;
            for (int i = 0; i < N; i++) begin
                act_q[i]  <= '0;
                pend_q[i] <= '0;
            end
        end else begin
            state_q      <= state_d;
            idx_q        <= idx_d;
            pend_v_q     <= pend_v_d;
            overflow_q   <= overflow_d;
            drop_count_q <= drop_count_d;
            act_q        <= act_d;
            pend_q       <= pend_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        idx_d        = idx_q;
        act_d        = act_q;
        pend_d       = pend_q;
        pend_v_d     = pend_v_q;
        overflow_d   = overflow_q;
        drop_count_d = drop_count_q;
        act_free     = !act_v;
        drop         = 1'b0;

        // End-of-vector decision first; acceptance below sees the resulting bank occupancy.
        if (fire) begin
            if (idx_q == LAST_IDX) begin
                idx_d = '0;
                if (pend_v_q) begin
                    act_d    = pend_q;
                    pend_v_d = 1'b0;
                end else begin
                    state_d  = StIdle;
                    act_free = 1'b1;
                end
            end else begin
                idx_d = idx_q + IDX_BITS'(1);
            end
        end

        if (in_valid) begin
            if (act_free) begin
                act_d   = in_vec;
                state_d = StStream;
                idx_d   = '0;
            end else if (!pend_v_d) begin
                pend_d   = in_vec;
                pend_v_d = 1'b1;
            end else begin
                drop = 1'b1;
            end
        end

        if (clear_overflow) begin
            overflow_d   = 1'b0;
            drop_count_d = '0;
        end

        // A drop in the clearing cycle still counts, starting again from one.
        if (drop) begin
            overflow_d = 1'b1;
            if (clear_overflow) begin
                drop_count_d = CNT_BITS'(1);
            end else if (drop_count_q != CNT_MAX) begin
                drop_count_d = drop_count_q + CNT_BITS'(1);
            end
        end
    end

    always_comb begin
        out.out_valid = act_v;
        out.out_data  = act_q[idx_q];
        out.out_index = idx_q;
        out.out_last  = act_v && (idx_q == LAST_IDX);
        busy          = act_v | pend_v_q;
        overflow      = overflow_q;
        drop_count    = drop_count_q;
    end
endmodule

// File: tb/tb_stream_out_vector_ping_pong.sv
// Directed bench for the vector ping-pong streamer: drives inputs #1 after each rising edge
// and checks the registered outputs in the same slot.
module tb_stream_out_vector_ping_pong;
    localparam int unsigned BITS     = 8;
    localparam int unsigned N        = 3;
    localparam int unsigned CNT_BITS = 8;

    logic                clk = 1'b0;
    logic                reset;
    logic                in_valid;
    logic [BITS-1:0]     in_vec [N];
    logic                clear_overflow;
    logic                busy;
    logic                overflow;
    logic [CNT_BITS-1:0] drop_count;

    int n_cmp = 0;
    int n_err = 0;

    stream_out_vector_ping_pong_if #(.BITS(BITS), .N(N)) sif ();

    stream_out_vector_ping_pong #(.BITS(BITS), .N(N), .CNT_BITS(CNT_BITS)) dut (
        .clk           (clk),
        .reset         (reset),
        .in_valid      (in_valid),
        .in_vec        (in_vec),
        .clear_overflow(clear_overflow),
        .busy          (busy),
        .overflow      (overflow),
        .drop_count    (drop_count),
        .out           (sif)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic set_vec(input logic [7:0] a, input logic [7:0] b, input logic [7:0] c);
        in_vec[0] = a;
        in_vec[1] = b;
        in_vec[2] = c;
    endtask

    // Checks one streamed element: valid, data, index and last flag.
    task automatic chk_elem(input string tag, input logic [7:0] d, input int idx);
        chk({tag, ".valid"}, {31'd0, sif.out_valid}, 32'd1);
        chk({tag, ".data"}, {24'd0, sif.out_data}, {24'd0, d});
        chk({tag, ".index"}, {30'd0, sif.out_index}, idx);
        chk({tag, ".last"}, {31'd0, sif.out_last}, (idx == N - 1) ? 32'd1 : 32'd0);
    endtask

    task automatic pulse(input logic [7:0] a, input logic [7:0] b, input logic [7:0] c);
        set_vec(a, b, c);
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        set_vec(8'hEE, 8'hEE, 8'hEE);
    endtask

    initial begin
        logic [7:0] t2_data [5];
        logic       t2_rdy  [5];
        int         t2_idx  [5];
        t2_data = '{8'h11, 8'h22, 8'h22, 8'h22, 8'h33};
        t2_rdy  = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1};
        t2_idx  = '{0, 1, 1, 1, 2};

        reset = 1'b1;
        in_valid = 1'b0;
        clear_overflow = 1'b0;
        sif.out_ready = 1'b0;
        set_vec(8'h00, 8'h00, 8'h00);
        tick();
        tick();
        reset = 1'b0;
        chk("rst.valid", {31'd0, sif.out_valid}, 32'd0);
        chk("rst.data", {24'd0, sif.out_data}, 32'd0);
        chk("rst.index", {30'd0, sif.out_index}, 32'd0);
        chk("rst.last", {31'd0, sif.out_last}, 32'd0);
        chk("rst.busy", {31'd0, busy}, 32'd0);
        chk("rst.ovf", {31'd0, overflow}, 32'd0);
        chk("rst.cnt", {24'd0, drop_count}, 32'd0);

        // 1: single vector with out_ready held high; later in_vec changes are ignored
        sif.out_ready = 1'b1;
        pulse(8'h11, 8'h22, 8'h33);
        chk_elem("t1.e0", 8'h11, 0);
        tick();
        chk_elem("t1.e1", 8'h22, 1);
        tick();
        chk_elem("t1.e2", 8'h33, 2);
        tick();
        chk("t1.valid_end", {31'd0, sif.out_valid}, 32'd0);
        chk("t1.busy_end", {31'd0, busy}, 32'd0);

        // 2: out_ready pattern 1,0,0,1,1 holds elements stable
        pulse(8'h11, 8'h22, 8'h33);
        for (int i = 0; i < 5; i++) begin
            sif.out_ready = t2_rdy[i];
            chk_elem($sformatf("t2.c%0d", i), t2_data[i], t2_idx[i]);
            tick();
        end
        chk("t2.valid_end", {31'd0, sif.out_valid}, 32'd0);

        // 3: back-to-back vectors, B lands in pending, no bubble
        sif.out_ready = 1'b1;
        pulse(8'd1, 8'd2, 8'd3);
        chk_elem("t3.a0", 8'd1, 0);
        pulse(8'd4, 8'd5, 8'd6);
        chk_elem("t3.a1", 8'd2, 1);
        chk("t3.busy", {31'd0, busy}, 32'd1);
        tick();
        chk_elem("t3.a2", 8'd3, 2);
        tick();
        chk_elem("t3.b0", 8'd4, 0);
        tick();
        chk_elem("t3.b1", 8'd5, 1);
        tick();
        chk_elem("t3.b2", 8'd6, 2);
        tick();
        chk("t3.valid_end", {31'd0, sif.out_valid}, 32'd0);
        chk("t3.ovf", {31'd0, overflow}, 32'd0);

        // 4: stalled output, third vector is dropped
        sif.out_ready = 1'b0;
        pulse(8'd1, 8'd2, 8'd3);
        pulse(8'd4, 8'd5, 8'd6);
        pulse(8'd7, 8'd8, 8'd9);
        chk("t4.ovf", {31'd0, overflow}, 32'd1);
        chk("t4.cnt", {24'd0, drop_count}, 32'd1);
        chk_elem("t4.hold", 8'd1, 0);
        sif.out_ready = 1'b1;
        for (int i = 0; i < 6; i++) begin
            chk_elem($sformatf("t4.d%0d", i), 8'(i + 1), i % 3);
            tick();
        end
        chk("t4.valid_end", {31'd0, sif.out_valid}, 32'd0);

        // 5: new vector arriving on the last-element fire refills active directly
        pulse(8'd1, 8'd2, 8'd3);
        chk_elem("t5.a0", 8'd1, 0);
        tick();
        chk_elem("t5.a1", 8'd2, 1);
        tick();
        chk_elem("t5.a2", 8'd3, 2);
        pulse(8'd7, 8'd8, 8'd9);
        chk_elem("t5.n0", 8'd7, 0);
        tick();
        chk_elem("t5.n1", 8'd8, 1);
        tick();
        chk_elem("t5.n2", 8'd9, 2);
        tick();
        chk("t5.valid_end", {31'd0, sif.out_valid}, 32'd0);
        chk("t5.ovf_still", {31'd0, overflow}, 32'd1);

        // clear alone, then drop coinciding with clear
        clear_overflow = 1'b1;
        tick();
        clear_overflow = 1'b0;
        chk("clr.ovf", {31'd0, overflow}, 32'd0);
        chk("clr.cnt", {24'd0, drop_count}, 32'd0);
        sif.out_ready = 1'b0;
        pulse(8'd1, 8'd2, 8'd3);
        pulse(8'd4, 8'd5, 8'd6);
        pulse(8'd7, 8'd8, 8'd9);
        pulse(8'd7, 8'd8, 8'd9);
        chk("clr.cnt2", {24'd0, drop_count}, 32'd2);
        clear_overflow = 1'b1;
        pulse(8'd7, 8'd8, 8'd9);
        clear_overflow = 1'b0;
        chk("clrdrop.ovf", {31'd0, overflow}, 32'd1);
        chk("clrdrop.cnt", {24'd0, drop_count}, 32'd1);

        // saturation: 300 more drops cap at 255
        for (int i = 0; i < 300; i++) pulse(8'd7, 8'd8, 8'd9);
        chk("sat.cnt", {24'd0, drop_count}, 32'd255);
        chk("sat.ovf", {31'd0, overflow}, 32'd1);
        chk_elem("sat.hold", 8'd1, 0);

        // 6: reset mid-stream with pending full
        sif.out_ready = 1'b1;
        tick();
        sif.out_ready = 1'b0;
        chk_elem("t6.pre", 8'd2, 1);
        chk("t6.pre_busy", {31'd0, busy}, 32'd1);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        chk("t6.valid", {31'd0, sif.out_valid}, 32'd0);
        chk("t6.busy", {31'd0, busy}, 32'd0);
        chk("t6.ovf", {31'd0, overflow}, 32'd0);
        chk("t6.cnt", {24'd0, drop_count}, 32'd0);
        sif.out_ready = 1'b1;
        tick();
        chk("t6.no_partial", {31'd0, sif.out_valid}, 32'd0);
        pulse(8'h0A, 8'h0B, 8'h0C);
        chk_elem("t6.e0", 8'h0A, 0);
        tick();
        chk_elem("t6.e1", 8'h0B, 1);
        tick();
        chk_elem("t6.e2", 8'h0C, 2);
        tick();
        chk("t6.valid_end", {31'd0, sif.out_valid}, 32'd0);
        chk("t6.busy_end", {31'd0, busy}, 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
